maxnet_cnt: RTL and testbench
=============================

# maxnet_cnt

Top-level iteration sequencer for the Maxnet winner-take-all datapath, sitting directly upstream of the PLU controller. It loads the initial activations, repeatedly launches one PLU pass (`plu_start`) and waits for its `plu_done`, then commits the PLU results back into the activation registers. It stops when exactly one activation is nonzero (winner found), when all are zero (no winner), or when the iteration cap is hit (timeout).

## Interface
- `N`, 4: number of neurons; `act_nz` width.
- `IDX_W`, 2: winner index width, equal to clog2(N).
- `MAX_ITER`, 31: maximum PLU passes before timeout; range 1..2^ITER_W-1.
- `ITER_W`, 5: iteration counter width.

Ports (direction, width, meaning):
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `start`, in, 1: begin a run; sampled only in IDLE.
- `plu_done`, in, 1: one-cycle pulse from the PLU marking the end of a pass.
- `act_nz`, in, N: per-neuron "activation register nonzero" flags; must be valid combinationally from the current activation registers.
- `init_ld`, out, 1: load external inputs into the activation registers.
- `plu_start`, out, 1: one-cycle PLU launch pulse.
- `act_ld`, out, 1: capture PLU results into the activation registers.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle completion pulse.
- `winner`, out, IDX_W: index of the surviving neuron.
- `winner_valid`, out, 1: `winner` is meaningful.
- `timeout`, out, 1: the run ended because the iteration cap was reached.
- `iter_cnt`, out, ITER_W: number of completed PLU passes in the current or last run.

## Operation
States: IDLE, INIT, CHECK, RUN, WAIT, UPDATE, FINISH. Outputs `init_ld`, `plu_start`, `act_ld`, `busy` and `done` are Moore-decoded from the state.

- **IDLE**
  - With `start`=1: go to INIT; clear `iter_cnt`, `winner`, `winner_valid` and `timeout`.
  - Otherwise stay in IDLE.
- **INIT:** `init_ld`=1; go to CHECK.
- **CHECK:** evaluate `pc = popcount(act_nz)`. The first matching rule wins:
  - `pc`==1: set `winner` to the index of the set bit, set `winner_valid`=1, go to FINISH.
  - `pc`==0: `winner_valid`=0, go to FINISH.
  - `iter_cnt`==MAX_ITER: set `timeout`=1, go to FINISH.
  - Otherwise: go to RUN.
- **RUN:** `plu_start`=1; go to WAIT.
- **WAIT:** stay until `plu_done`=1, then go to UPDATE.
- **UPDATE:** `act_ld`=1; `iter_cnt` += 1; go to CHECK.
- **FINISH:** `done`=1; go to IDLE.

Holding and boundary rules:
- `winner`, `winner_valid`, `timeout` and `iter_cnt` hold their values after FINISH until the next accepted `start`.
- `start` is ignored while `busy`=1.
- A `plu_done` pulse arriving in any state other than WAIT is ignored.
- `iter_cnt` never wraps, because the cap check happens before RUN.

## Timing
- Reset values: state is IDLE, and every output is 0: `init_ld`, `plu_start`, `act_ld`, `busy`, `done`, `winner`, `winner_valid`, `timeout`, `iter_cnt`.
- `rst` asserted mid-run forces IDLE on the next edge.
  - `plu_start` and `act_ld` drop immediately.
  - No `done` pulse is produced.
- Cycle accounting with `start` sampled at edge 0:
  - INIT is cycle 1; the first CHECK is cycle 2.
  - For an immediate winner, FINISH is cycle 3, with `done` high during cycle 3.
- Per iteration, paired with the PLU (which raises done 4 cycles after seeing `plu_start`):
  - Cycle c: RUN.
  - Cycles c+1..c+4: WAIT (`plu_done` is seen in c+4).
  - Cycle c+5: UPDATE.
  - Cycle c+6: CHECK.
  - Total is 6 cycles from RUN to the next CHECK, plus 1 for CHECK itself, so 7 cycles per pass.
- A slower PLU simply extends WAIT; correctness depends only on the `plu_done` pulse.
- `act_nz` is sampled in CHECK, one cycle after `act_ld`, so the registers have already updated.
- `busy` rises in the cycle after `start` is accepted and falls in the cycle after FINISH.

## Test plan
- **Reset:** hold `rst` 2 cycles with `start`=1 → all outputs 0, state IDLE, `busy`=0.
- **Immediate winner:** `start`, with `act_nz`=4'b0100 at CHECK → `done` at cycle 3, `winner`=2, `winner_valid`=1, `iter_cnt`=0, `plu_start` never asserted.
- **Two passes:** `act_nz` = 4'b1111, then 4'b1011 after the 1st `act_ld`, then 4'b0001 after the 2nd; the PLU model answers `plu_done` 4 cycles after `plu_start` → exactly 2 `plu_start` pulses spaced 7 cycles apart, `winner`=0, `iter_cnt`=2, single `done` pulse.
- **All zero:** `act_nz`=4'b0000 after the 1st pass → `done`, `winner_valid`=0, `timeout`=0, `iter_cnt`=1.
- **Timeout:** MAX_ITER=3, `act_nz` stuck at 4'b0011 → 3 passes, `timeout`=1, `winner_valid`=0, `iter_cnt`=3; `start` pulsed during WAIT has no effect.
- **Reset in WAIT:** assert `rst` in the 2nd WAIT cycle → IDLE next edge, no `done`, `iter_cnt`=0; a late `plu_done` is ignored and a fresh `start` runs normally.

Source files
------------

// File: rtl/maxnet_cnt.sv
// Maxnet iteration sequencer: loads activations, launches PLU passes and commits their results
// until one neuron survives, all die out, or the pass cap is reached.
module maxnet_cnt #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned MAX_ITER = 31,
  parameter int unsigned ITER_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              plu_done,
  input  logic [N-1:0]      act_nz,
  output logic              init_ld,
  output logic              plu_start,
  output logic              act_ld,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  winner,
  output logic              winner_valid,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [ITER_W-1:0] IterCap = ITER_W'(MAX_ITER);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StCheck,
    StRun,
    StWait,
    StUpdate,
    StFinish
  } state_e;

  state_e            state_q, state_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [IDX_W-1:0]  winner_q, winner_d;
  logic              winner_valid_q, winner_valid_d;
  logic              timeout_q, timeout_d;

  // Only pc==0, pc==1 and pc>=2 matter, so track "any" and "more than one" instead of a count.
  logic             any_nz;
  logic             multi_nz;
  logic [IDX_W-1:0] first_idx;

  always_comb begin
    any_nz    = 1'b0;
    multi_nz  = 1'b0;
    first_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (act_nz[i]) begin
        if (any_nz) begin
          multi_nz = 1'b1;
        end else begin
          first_idx = IDX_W'(i);
        end
        any_nz = 1'b1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    iter_cnt_d     = iter_cnt_q;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;
    timeout_d      = timeout_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d        = StInit;
          iter_cnt_d     = '0;
          winner_d       = '0;
          winner_valid_d = 1'b0;
          timeout_d      = 1'b0;
        end
      end
      StInit: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (any_nz && !multi_nz) begin
          winner_d       = first_idx;
          winner_valid_d = 1'b1;
          state_d        = StFinish;
        end else if (!any_nz) begin
          winner_valid_d = 1'b0;
          state_d        = StFinish;
        end else if (iter_cnt_q == IterCap) begin
          // Cap is checked before launching, so iter_cnt can never wrap.
          timeout_d = 1'b1;
          state_d   = StFinish;
        end else begin
          state_d = StRun;
        end
      end
      StRun: begin
        state_d = StWait;
      end
      StWait: begin
        if (plu_done) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        iter_cnt_d = iter_cnt_q + ITER_W'(1);
        state_d    = StCheck;
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      iter_cnt_q     <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      iter_cnt_q     <= iter_cnt_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
      timeout_q      <= timeout_d;
    end
  end

  always_comb begin
    init_ld      = (state_q == StInit);
    plu_start    = (state_q == StRun);
    act_ld       = (state_q == StUpdate);
    busy         = (state_q != StIdle);
    done         = (state_q == StFinish);
    winner       = winner_q;
    winner_valid = winner_valid_q;
    timeout      = timeout_q;
    iter_cnt     = iter_cnt_q;
  end

endmodule

// File: tb/tb_maxnet_cnt.sv
// Self-checking bench for maxnet_cnt: drives activation sequences and a PLU responder, and checks
// outcomes and cycle timing against a pass-by-pass behavioural model.
module tb_maxnet_cnt;

  localparam int unsigned Cap    = 3;
  localparam int unsigned Budget = 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       plu_done;
  logic [3:0] act_nz;
  logic       init_ld, plu_start, act_ld, busy, done, winner_valid, timeout;
  logic [1:0] winner;
  logic [4:0] iter_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Scenario: seq[k] is the activation pattern after k committed passes; dly[k] is the PLU latency
  // of pass k (cycles from plu_start to the cycle holding plu_done).
  logic [3:0]  seq [8];
  int unsigned dly [8];

  // Recorded behaviour of the last run.
  int unsigned r_done_rel, r_ndone, r_nstart, r_busy_gap;
  logic        r_busy_after, r_done_after;
  int unsigned r_start_rel [$];

  // Model outputs.
  int unsigned m_iter, m_done_rel;
  logic [1:0]  m_winner;
  logic        m_valid, m_timeout;

  maxnet_cnt #(
    .N       (4),
    .IDX_W   (2),
    .MAX_ITER(Cap),
    .ITER_W  (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .plu_done    (plu_done),
    .act_nz      (act_nz),
    .init_ld     (init_ld),
    .plu_start   (plu_start),
    .act_ld      (act_ld),
    .busy        (busy),
    .done        (done),
    .winner      (winner),
    .winner_valid(winner_valid),
    .timeout     (timeout),
    .iter_cnt    (iter_cnt)
  );

  initial forever #5 clk = ~clk;

  // Outcome and finish cycle of a run, walked pass by pass. First CHECK is cycle 2; each pass
  // costs RUN + WAIT(dly) + UPDATE + the following CHECK.
  task automatic compute_model();
    int unsigned k;
    int unsigned t;
    bit          fin;
    k = 0;
    t = 2;
    fin = 1'b0;
    m_valid = 1'b0;
    m_timeout = 1'b0;
    m_winner = 2'd0;
    while (!fin) begin
      if ($countones(seq[k]) == 1) begin
        m_valid = 1'b1;
        for (int i = 0; i < 4; i++) if (seq[k][i]) m_winner = 2'(i);
        fin = 1'b1;
      end else if ($countones(seq[k]) == 0) begin
        fin = 1'b1;
      end else if (k == Cap) begin
        m_timeout = 1'b1;
        fin = 1'b1;
      end else begin
        t = t + dly[k] + 3;
        k++;
      end
    end
    m_iter = k;
    m_done_rel = t + 1;
  endtask

  // Starts a run and plays the activation registers and the PLU until done or the budget runs out.
  // With spur set, also injects plu_done outside WAIT and start pulses while busy.
  task automatic drive_run(input bit spur);
    int unsigned rel;
    int unsigned cnt;
    int unsigned idx;
    r_ndone = 0;
    r_nstart = 0;
    r_busy_gap = 0;
    r_done_rel = 0;
    r_start_rel.delete();
    cnt = 0;
    idx = 0;
    @(negedge clk);
    start = 1'b1;
    plu_done = 1'b0;
    @(negedge clk);
    rel = 1;
    while (r_ndone == 0 && rel < Budget) begin
      plu_done = 1'b0;
      start = 1'b0;
      if (!busy) r_busy_gap++;
      if (done) begin
        r_ndone++;
        r_done_rel = rel;
      end
      if (init_ld) begin
        idx = 0;
        act_nz = seq[0];
      end
      if (act_ld) begin
        idx++;
        act_nz = seq[idx & 7];
        if (spur && $urandom_range(0, 1) == 1) plu_done = 1'b1;
      end
      if (plu_start) begin
        r_nstart++;
        r_start_rel.push_back(rel);
        cnt = dly[idx & 7];
        if (spur && $urandom_range(0, 1) == 1) plu_done = 1'b1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) plu_done = 1'b1;
      end
      if (spur && rel < m_done_rel && (cnt == 2 || $urandom_range(0, 3) == 0)) start = 1'b1;
      @(negedge clk);
      rel++;
    end
    plu_done = 1'b0;
    start = 1'b0;
    r_busy_after = busy;
    r_done_after = done;
    if (r_ndone == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL run_budget: no done within %0d cycles", Budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    plu_done = 1'b0;
    act_nz = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({init_ld, plu_start, act_ld, busy, done, winner, winner_valid, timeout, iter_cnt} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required all zero",
               {init_ld, plu_start, act_ld, busy, done, winner, winner_valid, timeout, iter_cnt});
    end
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_immediate();
    seq[0] = 4'b0100;
    for (int i = 0; i < 8; i++) dly[i] = 4;
    compute_model();
    drive_run(1'b0);
    vectors++;
    if (r_done_rel != 3) begin
      miscompares++;
      $display("FAIL imm_done_cycle: got %0d required 3", r_done_rel);
    end
    vectors++;
    if (winner !== m_winner || winner_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL imm_winner: got %0d/%b required %0d/1", winner, winner_valid, m_winner);
    end
    vectors++;
    if (iter_cnt !== 5'd0 || r_nstart != 0) begin
      miscompares++;
      $display("FAIL imm_no_pass: got iter %0d starts %0d required 0/0", iter_cnt, r_nstart);
    end
    vectors++;
    if (r_busy_after !== 1'b0 || r_busy_gap != 0) begin
      miscompares++;
      $display("FAIL imm_busy: got after %b gaps %0d required 0/0", r_busy_after, r_busy_gap);
    end
  endtask

  task automatic test_two_passes();
    seq[0] = 4'b1111;
    seq[1] = 4'b1011;
    seq[2] = 4'b0001;
    for (int i = 0; i < 8; i++) dly[i] = 4;
    compute_model();
    drive_run(1'b0);
    vectors++;
    if (r_nstart != 2) begin
      miscompares++;
      $display("FAIL two_start_count: got %0d required 2", r_nstart);
    end else begin
      vectors++;
      if (r_start_rel[1] - r_start_rel[0] != 7 || r_start_rel[0] != 3) begin
        miscompares++;
        $display("FAIL two_start_spacing: got %0d,%0d required 3,10", r_start_rel[0], r_start_rel[1]);
      end
    end
    vectors++;
    if (winner !== 2'd0 || winner_valid !== 1'b1 || iter_cnt !== 5'd2) begin
      miscompares++;
      $display("FAIL two_result: got w%0d v%b it%0d required w0 v1 it2", winner, winner_valid, iter_cnt);
    end
    vectors++;
    if (r_done_rel != m_done_rel || r_done_after !== 1'b0) begin
      miscompares++;
      $display("FAIL two_done: got cycle %0d after %b required %0d/0", r_done_rel, r_done_after,
               m_done_rel);
    end
  endtask

  task automatic test_all_zero();
    seq[0] = 4'b1111;
    seq[1] = 4'b0000;
    for (int i = 0; i < 8; i++) dly[i] = 4;
    compute_model();
    drive_run(1'b0);
    vectors++;
    if (winner_valid !== 1'b0 || timeout !== 1'b0 || iter_cnt !== 5'd1) begin
      miscompares++;
      $display("FAIL zero_result: got v%b t%b it%0d required v0 t0 it1", winner_valid, timeout,
               iter_cnt);
    end
    vectors++;
    if (r_done_rel != m_done_rel) begin
      miscompares++;
      $display("FAIL zero_done_cycle: got %0d required %0d", r_done_rel, m_done_rel);
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 8; i++) begin
      seq[i] = 4'b0011;
      dly[i] = 4;
    end
    compute_model();
    drive_run(1'b1);
    vectors++;
    if (timeout !== 1'b1 || winner_valid !== 1'b0 || iter_cnt !== 5'(Cap)) begin
      miscompares++;
      $display("FAIL to_result: got t%b v%b it%0d required t1 v0 it%0d", timeout, winner_valid,
               iter_cnt, Cap);
    end
    vectors++;
    if (r_nstart != Cap || r_done_rel != 24 || r_ndone != 1) begin
      miscompares++;
      $display("FAIL to_timing: got starts %0d done %0d required %0d/24", r_nstart, r_done_rel, Cap);
    end
  endtask

  // Results hold in IDLE while the PLU and activations keep toggling.
  task automatic test_hold();
    for (int c = 0; c < 6; c++) begin
      plu_done = 1'($urandom_range(0, 1));
      act_nz = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    plu_done = 1'b0;
    vectors++;
    if (iter_cnt !== 5'(m_iter) || timeout !== m_timeout || winner_valid !== m_valid || busy !== 1'b0)
    begin
      miscompares++;
      $display("FAIL hold_results: got it%0d t%b v%b b%b required it%0d t%b v%b b0", iter_cnt,
               timeout, winner_valid, busy, m_iter, m_timeout, m_valid);
    end
  endtask

  task automatic test_reset_wait();
    act_nz = 4'b1111;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (plu_start !== 1'b1) begin
      miscompares++;
      $display("FAIL rw_run: got plu_start %b required 1", plu_start);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, plu_start, act_ld} !== 4'b0000 || iter_cnt !== 5'd0) begin
      miscompares++;
      $display("FAIL rw_abort: got bdpa %b it%0d required 0000 it0", {busy, done, plu_start, act_ld},
               iter_cnt);
    end
    rst = 1'b0;
    plu_done = 1'b1;
    @(negedge clk);
    plu_done = 1'b0;
    vectors++;
    if ({busy, done, act_ld} !== 3'b000) begin
      miscompares++;
      $display("FAIL rw_late_done: got bda %b required 000", {busy, done, act_ld});
    end
    seq[0] = 4'b0010;
    compute_model();
    drive_run(1'b0);
    vectors++;
    if (winner !== 2'd1 || winner_valid !== 1'b1 || r_done_rel != 3) begin
      miscompares++;
      $display("FAIL rw_restart: got w%0d v%b cycle %0d required w1 v1 cycle 3", winner,
               winner_valid, r_done_rel);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 8; i++) begin
        seq[i] = 4'($urandom_range(0, 15));
        dly[i] = $urandom_range(1, 6);
      end
      compute_model();
      drive_run(1'b1);
      vectors++;
      if (iter_cnt !== 5'(m_iter) || timeout !== m_timeout || winner_valid !== m_valid) begin
        miscompares++;
        $display("FAIL rand_result[%0d]: got it%0d t%b v%b required it%0d t%b v%b", n, iter_cnt,
                 timeout, winner_valid, m_iter, m_timeout, m_valid);
      end
      if (m_valid) begin
        vectors++;
        if (winner !== m_winner) begin
          miscompares++;
          $display("FAIL rand_winner[%0d]: got %0d required %0d", n, winner, m_winner);
        end
      end
      vectors++;
      if (r_done_rel != m_done_rel || r_nstart != m_iter || r_busy_gap != 0 || r_busy_after !== 1'b0)
      begin
        miscompares++;
        $display("FAIL rand_timing[%0d]: got done %0d starts %0d gaps %0d required %0d/%0d/0", n,
                 r_done_rel, r_nstart, r_busy_gap, m_done_rel, m_iter);
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    plu_done = 1'b0;
    act_nz = 4'd0;
    test_reset();
    test_immediate();
    test_two_passes();
    test_all_zero();
    test_timeout();
    test_hold();
    test_reset_wait();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
